instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the control unit in the 19-bit CPU.
//  Owns the PC, issues single-outstanding reads to instruction memory and buffers returned words in a DEPTH-entry FIFO.
//  Presents instruction, OPCODE and PC to the control unit over a valid/ready handshake.
//  Accepts PC redirects (branch/jump) from the control unit and squashes stale fetches.
// PARAMETERS
//  INSTR_W  19  instruction width; OPCODE = INSTR[INSTR_W-1 -: OPC_W]
//  OPC_W    5   opcode field width
//  ADDR_W   19  PC / instruction memory word-address width
//  DEPTH    2   prefetch FIFO entries (power of 2, >=2)
//  RESET_PC 0   PC value loaded on reset
// PORTS
//  CLK           in   1        clock, rising edge
//  RST           in   1        asynchronous, active-high reset
//  IMEM_REQ      out  1        read request, held until IMEM_ACK
//  IMEM_ADDR     out  ADDR_W   word address of request, stable while IMEM_REQ
//  IMEM_ACK      in   1        read complete; IMEM_RDATA valid this cycle
//  IMEM_RDATA    in   INSTR_W  returned instruction word
//  INSTR_VALID   out  1        FIFO head valid
//  INSTR_READY   in   1        control unit consumes head this cycle
//  INSTR         out  INSTR_W  FIFO head instruction
//  OPCODE        out  OPC_W    INSTR[INSTR_W-1 -: OPC_W]
//  INSTR_PC      out  ADDR_W   address the head instruction was fetched from
//  REDIRECT      in   1        PC redirect request (1-cycle pulse)
//  REDIRECT_PC   in   ADDR_W   new fetch address
// BEHAVIOUR
//  Reset (async assert, any cycle): PC=RESET_PC, FIFO empty, state=IDLE, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_VALID=0, INSTR/OPCODE/INSTR_PC=0.
//  An in-flight memory transaction at reset is abandoned; the bench holds IMEM_ACK low while RST=1.
//  FSM states:
//   IDLE: no request. Goes to REQ when credit = (count < DEPTH) and no REDIRECT this cycle.
//   REQ: IMEM_REQ=1, IMEM_ADDR=PC.
//    - On IMEM_ACK without REDIRECT: push {RDATA, PC}, PC <= PC+1, then REQ if credit remains after the push and pop, else IDLE.
//    - On REDIRECT without ACK: go to DROP.
//    - On REDIRECT with ACK: discard data, go to IDLE.
//   DROP: IMEM_REQ=1 (same address, never withdrawn mid-request). On ACK: discard data, go to IDLE. A further REDIRECT in DROP updates PC only.
//  Redirect (any state): FIFO flushed, PC <= REDIRECT_PC on that edge, INSTR_VALID=0 the next cycle.
//   - A pop in the same cycle is still a legal handshake; the CU discards it.
//   - First request to REDIRECT_PC is issued the cycle after the squash completes (IDLE->REQ).
//  FIFO: push and pop in the same cycle are legal at any count, including full (count unchanged).
//   - Pop when INSTR_VALID && INSTR_READY.
//   - INSTR/OPCODE/INSTR_PC are held stable while INSTR_VALID && !INSTR_READY.
//  Latency: ACK at edge N gives INSTR_VALID=1 after edge N (registered FIFO output; no RDATA->INSTR bypass).
//   - After reset release, IMEM_REQ rises in the 2nd cycle (IDLE->REQ).
//  PC arithmetic: modulo 2^ADDR_W; PC=2^ADDR_W-1 increments to 0 with no flag.
//  IMEM_ACK while IMEM_REQ=0: ignored. INSTR_READY while INSTR_VALID=0: ignored.
//  At most one outstanding request. count + outstanding never exceeds DEPTH.
// TESTING
//  1. Reset release; memory returns 0x0A001 @0, 0x14002 @1 with 1-cycle ACK, INSTR_READY=1 -> INSTR_PC 0,1 in order; OPCODE 0x02 then 0x05.
//  2. INSTR_READY=0, DEPTH=2 -> exactly 2 ACKs then IMEM_REQ=0. Raise READY for 1 cycle -> one pop, one new request at PC=2.
//  3. REDIRECT to 0x00100 while request @5 pending, ACK 3 cycles later -> data @5 dropped; next IMEM_ADDR=0x00100; INSTR_VALID=0 until its ACK.
//  4. REDIRECT_PC=0x7FFFF, continuous ACKs -> fetched PCs 0x7FFFF, 0x00000, 0x00001.
//  5. FIFO full, READY=1 and ACK in same cycle -> count stays 2; order preserved; no lost or duplicated PC.
//  6. Assert RST mid-REQ with FIFO holding 1 entry -> INSTR_VALID and IMEM_REQ drop immediately (async); after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues one instruction-memory read at a time,
// buffers returned words in a small prefetch FIFO and hands them to the
// control unit over a valid/ready handshake. Redirects flush the FIFO and
// squash any read that is still in flight.
module instr_fetch_unit #(
   parameter int          INSTR_W  = 19,
   parameter int          OPC_W    = 5,
   parameter int          ADDR_W   = 19,
   parameter int          DEPTH    = 2,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               CLK,
   input  logic               RST,
   output logic               IMEM_REQ,
   output logic [ADDR_W-1:0]  IMEM_ADDR,
   input  logic               IMEM_ACK,
   input  logic [INSTR_W-1:0] IMEM_RDATA,
   output logic               INSTR_VALID,
   input  logic               INSTR_READY,
   output logic [INSTR_W-1:0] INSTR,
   output logic [OPC_W-1:0]   OPCODE,
   output logic [ADDR_W-1:0]  INSTR_PC,
   input  logic               REDIRECT,
   input  logic [ADDR_W-1:0]  REDIRECT_PC
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
   localparam logic [CNT_W-1:0]  DEPTH_V    = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

   // IDLE: no request; REQ: live request; DROP: request whose data is stale
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t             state_reg;
   logic [ADDR_W-1:0]  pc_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic               req_reg;

   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [CNT_W-1:0]   count_next;

   logic [INSTR_W-1:0] data_mem [DEPTH];
   logic [ADDR_W-1:0]  pc_mem   [DEPTH];
   logic [DEPTH-1:0]   wr_en;

   logic               push;
   logic               pop;
   logic [ADDR_W-1:0]  pc_inc;

   // Only a live (non-squashed) request may write the FIFO; a redirect
   // suppresses both push and pop because the FIFO is flushed anyway.
   assign push       = (state_reg == ST_REQ) && IMEM_ACK && !REDIRECT;
   assign pop        = (count_reg != '0) && INSTR_READY && !REDIRECT;
   assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
   assign pc_inc     = pc_reg + ADDR_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   // Fetch FSM: advances the PC, drives the request strobe and its address
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC_V;
         addr_reg  <= RESET_PC_V;
         req_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (REDIRECT) begin
                  pc_reg <= REDIRECT_PC;
               end else if (count_reg < DEPTH_V) begin
                  state_reg <= ST_REQ;
                  req_reg   <= 1'b1;
                  addr_reg  <= pc_reg;
               end
            end
            ST_REQ: begin
               if (REDIRECT) begin
                  pc_reg <= REDIRECT_PC;
                  if (IMEM_ACK) begin
                     state_reg <= ST_IDLE;
                     req_reg   <= 1'b0;
                  end else begin
                     // keep the request up at its old address until it completes
                     state_reg <= ST_DROP;
                  end
               end else if (IMEM_ACK) begin
                  pc_reg <= pc_inc;
                  if (count_next < DEPTH_V) begin
                     addr_reg <= pc_inc;
                  end else begin
                     state_reg <= ST_IDLE;
                     req_reg   <= 1'b0;
                  end
               end
            end
            ST_DROP: begin
               if (REDIRECT) begin
                  pc_reg <= REDIRECT_PC;
               end
               if (IMEM_ACK) begin
                  state_reg <= ST_IDLE;
                  req_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               req_reg   <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; a redirect empties the FIFO
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (REDIRECT) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         count_reg <= count_next;
      end
   end

   // FIFO storage: instruction word plus the address it came from
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               data_mem[i] <= IMEM_RDATA;
               pc_mem[i]   <= pc_reg;
            end
         end
      end
   end

   assign IMEM_REQ    = req_reg;
   assign IMEM_ADDR   = addr_reg;
   assign INSTR_VALID = (count_reg != '0);
   assign INSTR       = data_mem[rd_ptr_reg];
   assign INSTR_PC    = pc_mem[rd_ptr_reg];
   assign OPCODE      = INSTR[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed sequences, a table of redirect vectors and a
// randomized run against a queue-based reference of the fetch stream.
module tb_instr_fetch_unit;

   localparam int DEPTH = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IMEM_REQ;
   logic [18:0] IMEM_ADDR;
   logic        IMEM_ACK = 1'b0;
   logic [18:0] IMEM_RDATA = '0;
   logic        INSTR_VALID;
   logic        INSTR_READY = 1'b0;
   logic [18:0] INSTR;
   logic [4:0]  OPCODE;
   logic [18:0] INSTR_PC;
   logic        REDIRECT = 1'b0;
   logic [18:0] REDIRECT_PC = '0;

   instr_fetch_unit dut (
      .CLK(CLK), .RST(RST),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
      .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
      .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .INSTR(INSTR), .OPCODE(OPCODE), .INSTR_PC(INSTR_PC),
      .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // memory responder knobs
   int wait_cnt = 0;
   int cur_lat = 0;
   int lat_min = 0;
   int lat_max = 0;
   int acks = 0;
   bit spurious = 1'b0;

   logic [18:0] got_pc [16];
   logic [4:0]  got_op [16];
   int          got_n;

   typedef struct {
      logic [18:0] redir_pc;
      int          lat;
      logic [18:0] pc [3];
      logic [4:0]  op [3];
   } vec_t;
   vec_t tbl [4];

   function automatic logic [18:0] mem_word(input logic [18:0] a);
      if (a == 19'd0) return 19'h0A001;
      if (a == 19'd1) return 19'h14002;
      return a ^ 19'h2AAAA;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock: wait past the edge, then play the memory side
   task automatic tick();
      @(posedge CLK);
      #1;
      if (IMEM_ACK) begin
         IMEM_ACK = 1'b0;
         wait_cnt = 0;
         cur_lat  = $urandom_range(lat_max, lat_min);
      end
      if (!RST && IMEM_REQ) begin
         if (wait_cnt >= cur_lat) begin
            IMEM_ACK   = 1'b1;
            IMEM_RDATA = mem_word(IMEM_ADDR);
            acks++;
         end else begin
            wait_cnt++;
         end
      end else if (!RST && spurious && $urandom_range(3, 0) == 0) begin
         IMEM_ACK   = 1'b1;
         IMEM_RDATA = 19'($urandom);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      IMEM_ACK = 1'b0;
      REDIRECT = 1'b0;
      wait_cnt = 0;
      cur_lat = lat_min;
      repeat (3) tick();
      RST = 1'b0;
      acks = 0;
   endtask

   task automatic collect(input int n, input int limit);
      got_n = 0;
      for (int c = 0; c < limit && got_n < n; c++) begin
         if (INSTR_VALID && INSTR_READY && !REDIRECT) begin
            got_pc[got_n] = INSTR_PC;
            got_op[got_n] = OPCODE;
            got_n++;
         end
         tick();
      end
   endtask

   // Reference: the delivered stream is consecutive fetch addresses from the
   // last reset/redirect target, minus whatever a redirect flushed.
   logic [18:0] q_pc [$];
   logic [18:0] exp_fetch = '0;
   logic [18:0] stale_addr = '0;
   bit          stale = 1'b0;

   initial begin
      forever begin
         @(negedge CLK);
         if (RST) begin
            q_pc.delete();
            exp_fetch = 19'd0;
            stale = 1'b0;
            check("rst_req", IMEM_REQ, 0);
            check("rst_valid", INSTR_VALID, 0);
            check("rst_addr", IMEM_ADDR, 0);
            check("rst_instr", INSTR, 0);
            check("rst_opcode", OPCODE, 0);
            check("rst_instr_pc", INSTR_PC, 0);
         end else begin
            check("valid", INSTR_VALID, (q_pc.size() != 0) ? 1 : 0);
            if (INSTR_VALID && q_pc.size() != 0) begin
               check("instr_pc", INSTR_PC, q_pc[0]);
               check("instr", INSTR, mem_word(q_pc[0]));
               check("opcode", OPCODE, mem_word(q_pc[0]) >> 14);
            end
            if (IMEM_REQ) check("imem_addr", IMEM_ADDR, stale ? stale_addr : exp_fetch);
            check("credit", ((q_pc.size() + int'(IMEM_REQ)) <= DEPTH) ? 1 : 0, 1);
            if (INSTR_VALID && INSTR_READY && !REDIRECT && q_pc.size() != 0) void'(q_pc.pop_front());
            if (IMEM_REQ && IMEM_ACK) begin
               if (!stale && !REDIRECT) begin
                  q_pc.push_back(exp_fetch);
                  exp_fetch = exp_fetch + 19'd1;
               end
               stale = 1'b0;
            end
            if (REDIRECT) begin
               if (IMEM_REQ && !IMEM_ACK) begin
                  if (!stale) stale_addr = exp_fetch;
                  stale = 1'b1;
               end
               q_pc.delete();
               exp_fetch = REDIRECT_PC;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      tbl[0] = '{19'h00100, 0, '{19'h00100, 19'h00101, 19'h00102}, '{5'h0A, 5'h0A, 5'h0A}};
      tbl[1] = '{19'h7FFFF, 0, '{19'h7FFFF, 19'h00000, 19'h00001}, '{5'h15, 5'h02, 5'h05}};
      tbl[2] = '{19'h40000, 1, '{19'h40000, 19'h40001, 19'h40002}, '{5'h1A, 5'h1A, 5'h1A}};
      tbl[3] = '{19'h7FFFE, 2, '{19'h7FFFE, 19'h7FFFF, 19'h00000}, '{5'h15, 5'h15, 5'h02}};

      #1;
      // 1: first fetches after reset
      lat_min = 0; lat_max = 0; INSTR_READY = 1'b1;
      do_reset();
      check("t1_req_cycle1", IMEM_REQ, 0);
      tick();
      check("t1_req_cycle2", IMEM_REQ, 1);
      check("t1_addr0", IMEM_ADDR, 0);
      collect(2, 20);
      check("t1_count", got_n, 2);
      check("t1_pc0", got_pc[0], 19'd0);
      check("t1_op0", got_op[0], 5'h02);
      check("t1_pc1", got_pc[1], 19'd1);
      check("t1_op1", got_op[1], 5'h05);
      $display("t1 reset fetch: pcs %0h %0h ops %0h %0h", got_pc[0], got_pc[1], got_op[0], got_op[1]);

      // 2: back-pressure stops fetching at DEPTH entries
      INSTR_READY = 1'b0;
      do_reset();
      repeat (12) tick();
      check("t2_acks", acks, 2);
      check("t2_req_low", IMEM_REQ, 0);
      check("t2_valid", INSTR_VALID, 1);
      check("t2_head", INSTR_PC, 19'd0);
      INSTR_READY = 1'b1;
      tick();
      INSTR_READY = 1'b0;
      for (int c = 0; c < 10 && !IMEM_REQ; c++) tick();
      check("t2_req_again", IMEM_REQ, 1);
      check("t2_addr2", IMEM_ADDR, 19'd2);
      repeat (8) tick();
      check("t2_acks_total", acks, 3);
      check("t2_req_low2", IMEM_REQ, 0);
      check("t2_head2", INSTR_PC, 19'd1);
      $display("t2 backpressure: acks %0d head %0h", acks, INSTR_PC);

      // 3: redirect while a request is pending; its data must be dropped
      lat_min = 3; lat_max = 3; INSTR_READY = 1'b1;
      do_reset();
      for (int c = 0; c < 100 && !(IMEM_REQ && IMEM_ADDR == 19'd5 && !IMEM_ACK); c++) tick();
      check("t3_pending5", (IMEM_REQ && IMEM_ADDR == 19'd5) ? 1 : 0, 1);
      REDIRECT = 1'b1; REDIRECT_PC = 19'h00100;
      tick();
      REDIRECT = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         check("t3_valid_low", INSTR_VALID, 0);
         if (IMEM_REQ) check("t3_addr", (IMEM_ADDR == 19'd5 || IMEM_ADDR == 19'h00100) ? 1 : 0, 1);
         if (IMEM_REQ && IMEM_ACK && IMEM_ADDR == 19'h00100) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      check("t3_new_ack", got, 1);
      tick();
      check("t3_valid", INSTR_VALID, 1);
      check("t3_pc", INSTR_PC, 19'h00100);
      $display("t3 squash: new head %0h", INSTR_PC);

      // table: redirect targets incl. PC wrap
      INSTR_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lat_min = tbl[i].lat; lat_max = tbl[i].lat;
         tick();
         REDIRECT = 1'b1; REDIRECT_PC = tbl[i].redir_pc;
         tick();
         REDIRECT = 1'b0;
         check($sformatf("tbl%0d_flush", i), INSTR_VALID, 0);
         collect(3, 60);
         check($sformatf("tbl%0d_count", i), got_n, 3);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("tbl%0d_pc%0d", i, k), got_pc[k], tbl[i].pc[k]);
            check($sformatf("tbl%0d_op%0d", i, k), got_op[k], tbl[i].op[k]);
         end
         $display("tbl%0d redirect %0h: pcs %0h %0h %0h", i, tbl[i].redir_pc, got_pc[0], got_pc[1], got_pc[2]);
      end

      // 5: drain from full with concurrent refills keeps order
      lat_min = 0; lat_max = 0; INSTR_READY = 1'b0;
      do_reset();
      repeat (8) tick();
      check("t5_full_head", INSTR_PC, 19'd0);
      INSTR_READY = 1'b1;
      collect(12, 40);
      check("t5_count", got_n, 12);
      for (int k = 0; k < got_n; k++) check($sformatf("t5_pc%0d", k), got_pc[k], 19'(k));
      $display("t5 stream: %0d pops, last pc %0h", got_n, got_pc[11]);

      // 6: asynchronous reset mid-request with one entry buffered
      lat_min = 4; lat_max = 4; INSTR_READY = 1'b0;
      do_reset();
      for (int c = 0; c < 40 && !(INSTR_VALID && IMEM_REQ); c++) tick();
      check("t6_setup", (INSTR_VALID && IMEM_REQ) ? 1 : 0, 1);
      #2;
      RST = 1'b1;
      IMEM_ACK = 1'b0;
      #1;
      check("t6_valid_async", INSTR_VALID, 0);
      check("t6_req_async", IMEM_REQ, 0);
      wait_cnt = 0; cur_lat = lat_min;
      repeat (2) tick();
      RST = 1'b0;
      for (int c = 0; c < 10 && !IMEM_REQ; c++) tick();
      check("t6_restart_req", IMEM_REQ, 1);
      check("t6_restart_addr", IMEM_ADDR, 19'd0);
      $display("t6 async reset: restart addr %0h", IMEM_ADDR);

      // randomized traffic checked by the reference
      lat_min = 0; lat_max = 3; spurious = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         INSTR_READY = ($urandom_range(9, 0) < 6);
         REDIRECT = ($urandom_range(19, 0) == 0);
         if ($urandom_range(3, 0) == 0) REDIRECT_PC = 19'h7FFFF - 19'($urandom_range(2, 0));
         else REDIRECT_PC = 19'($urandom);
      end
      tick();
      REDIRECT = 1'b0; spurious = 1'b0; INSTR_READY = 1'b1;
      lat_min = 0; lat_max = 1;
      collect(10, 80);
      check("rand_liveness", got_n, 10);
      $display("random run: 3000 cycles, final pops %0d", got_n);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
